// File: rtl/snpu_pkg.sv
// Shared definitions for the policy deck: opcodes, FSM states, deck
// constants and the card-removal helper used by the top level.
package snpu_pkg;

    localparam int DECK_SIZE = 17;
    localparam int LIB_TOTAL = 6;
    localparam int LIB_WIN   = 5;
    localparam int FAS_WIN   = 6;

    // Freshly built deck: six liberals on top, eleven fascists below.
    localparam logic [DECK_SIZE-1:0] DECK_INIT = 17'h0003F;
    localparam logic [7:0]           LFSR_INIT = 8'h01;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_INIT    = 3'd1,
        OP_SHUFFLE = 3'd2,
        OP_DISCARD = 3'd3,
        OP_PLAY    = 3'd4,
        OP_SEED    = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MERGE,
        ST_SWAP
    } state_e;

    // Drop card idx from the pile: cards above idx slide down one place,
    // cards below idx stay put, and the vacated top bit becomes 0.
    function automatic logic [DECK_SIZE-1:0] remove_card(
        input logic [DECK_SIZE-1:0] pile,
        input logic [1:0]           idx
    );
        logic [DECK_SIZE-1:0] keep;
        keep = (DECK_SIZE'(1) << idx) - DECK_SIZE'(1);
        return (pile & keep) | ((pile >> 1) & ~keep);
    endfunction

endpackage

// File: rtl/snpu_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 7,5,4,3, shift left) used as the shuffle
// random source.
// Ports: clk, rst_n (async active-low), load (take seed this cycle),
//        seed (value to load; 0 is replaced by 1), q (current state).
module snpu_lfsr8
    import snpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= LFSR_INIT;
        end else if (load) begin
            // An all-zero state would lock the LFSR up forever.
            q <= (seed == 8'h00) ? LFSR_INIT : seed;
        end else begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/policy_deck.sv
// Policy card deck: draw pile (bit 0 = top, 1 = liberal), discard pile kept
// as counts, board tallies, and a merge + Fisher-Yates shuffle engine.
// Ports: clk, rst_n (async active-low); op_valid/op_ready handshake with
//        op_code, op_idx, seed; hand = top three cards; draw_n/discard_n
//        pile sizes; lib_played/fas_played board; game_over; op_err
//        one-cycle error pulse; busy while a shuffle runs.
module policy_deck
    import snpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] op_code,
    input  logic [1:0] op_idx,
    input  logic [7:0] seed,
    output logic [2:0] hand,
    output logic [4:0] draw_n,
    output logic [4:0] discard_n,
    output logic [2:0] lib_played,
    output logic [2:0] fas_played,
    output logic       game_over,
    output logic       op_err,
    output logic       busy
);

    state_e               state;
    logic [DECK_SIZE-1:0] draw;
    logic [4:0]           disc_lib;
    logic [4:0]           swap_i;
    logic [7:0]           lfsr;
    logic                 lfsr_unused;

    logic                 lfsr_load;
    logic                 card;
    logic                 idx_bad;
    logic [DECK_SIZE-1:0] removed;
    logic [DECK_SIZE-1:0] lib_mask;
    logic [DECK_SIZE-1:0] swapped;
    logic [4:0]           merged_n;
    logic [4:0]           swap_j;

    assign op_ready    = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign hand        = draw[2:0];
    assign game_over   = (lib_played == 3'(LIB_WIN)) || (fas_played == 3'(FAS_WIN));
    assign swap_j      = lfsr[4:0];
    assign lfsr_unused = ^lfsr[7:5];

    snpu_lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (seed),
        .q     (lfsr)
    );

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it holding a value (latch).
    always_comb begin
        lfsr_load = 1'b0;
        card      = draw[op_idx];
        removed   = remove_card(draw, op_idx);
        // Indices past the live pile would pull in phantom fascists.
        idx_bad   = (op_idx == 2'd3) || ({3'b000, op_idx} >= draw_n);
        merged_n  = draw_n + discard_n;
        // Discard liberals land directly above the live draw pile; the
        // discarded fascists follow as zeros.
        lib_mask  = ((DECK_SIZE'(1) << disc_lib) - DECK_SIZE'(1)) << draw_n;
        swapped   = draw;
        swapped[swap_i] = draw[swap_j];
        swapped[swap_j] = draw[swap_i];
        if (op_valid && state == ST_IDLE && op_code == OP_SEED) begin
            lfsr_load = 1'b1;
        end
    end

    // NOTE: the draw pile is a flop vector rather than a RAM, so it can and
    // does take a reset value along with the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            draw       <= DECK_INIT;
            draw_n     <= 5'(DECK_SIZE);
            discard_n  <= '0;
            disc_lib   <= '0;
            lib_played <= '0;
            fas_played <= '0;
            swap_i     <= '0;
            op_err     <= 1'b0;
        end else begin
            op_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            OP_NOP, OP_SEED: ;
                            OP_INIT: begin
                                draw       <= DECK_INIT;
                                draw_n     <= 5'(DECK_SIZE);
                                discard_n  <= '0;
                                disc_lib   <= '0;
                                lib_played <= '0;
                                fas_played <= '0;
                            end
                            OP_SHUFFLE: state <= ST_MERGE;
                            OP_DISCARD, OP_PLAY: begin
                                if (idx_bad || (op_code == OP_PLAY && game_over)) begin
                                    op_err <= 1'b1;
                                end else begin
                                    draw   <= removed;
                                    draw_n <= draw_n - 5'd1;
                                    if (op_code == OP_DISCARD) begin
                                        discard_n <= discard_n + 5'd1;
                                        disc_lib  <= disc_lib + {4'b0000, card};
                                    end else if (card) begin
                                        lib_played <= lib_played + 3'd1;
                                    end else begin
                                        fas_played <= fas_played + 3'd1;
                                    end
                                    // Fewer than a full hand left: reshuffle.
                                    if (draw_n - 5'd1 < 5'd3) begin
                                        state <= ST_MERGE;
                                    end
                                end
                            end
                            default: op_err <= 1'b1;
                        endcase
                    end
                end
                ST_MERGE: begin
                    draw      <= draw | lib_mask;
                    draw_n    <= merged_n;
                    discard_n <= '0;
                    disc_lib  <= '0;
                    swap_i    <= merged_n - 5'd1;
                    state     <= ST_SWAP;
                end
                ST_SWAP: begin
                    if (draw_n <= 5'd1 || swap_i == 5'd0) begin
                        state <= ST_IDLE;
                    end else if (swap_j <= swap_i) begin
                        draw   <= swapped;
                        swap_i <= swap_i - 5'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/policy_deck.md
POLICY_DECK -- requirements
Module: policy_deck

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: op_valid  in  1  request valid; op_ready  out  1  accept-ready; op_code  in  3  operation; op_idx  in  2  card index into top of draw pile; seed  in  8  LFSR seed for SEED op.
REQ-003 SHALL have ports: hand  out  3  draw[2:0], top three cards (1=liberal, 0=fascist); draw_n  out  5  draw-pile count; discard_n  out  5  discard-pile count.
REQ-004 SHALL have ports: lib_played  out  3; fas_played  out  3; game_over  out  1; op_err  out  1  one-cycle error pulse; busy  out  1  shuffle in progress.

Function
REQ-005 Opcodes SHALL be: 0 NOP, 1 INIT, 2 SHUFFLE, 3 DISCARD, 4 PLAY, 5 SEED; codes 6-7 SHALL pulse op_err with no state change.
REQ-006 An op SHALL be accepted on a cycle with op_valid=1 and op_ready=1; op_ready=1 only in IDLE.
REQ-007 Draw pile SHALL be a 17-bit vector, bit 0 = top; bits at or above draw_n SHALL read 0.
REQ-008 Discard pile SHALL be held as total count plus liberal count.
REQ-009 INIT SHALL set draw=17'h0003F, draw_n=17, discard and board counts 0, game_over=0, completing in one cycle.
REQ-010 DISCARD SHALL remove card op_idx from draw (lower-index bits kept, higher bits shift down one), decrement draw_n, and add the card to the discard pile; one cycle.
REQ-011 PLAY SHALL remove card op_idx as in REQ-010 and increment lib_played (card 1) or fas_played (card 0); one cycle.
REQ-012 DISCARD or PLAY with op_idx=3 SHALL pulse op_err with no state change.
REQ-013 PLAY while game_over=1 SHALL pulse op_err with no state change.
REQ-014 game_over SHALL be 1 when lib_played==5 or fas_played==6.
REQ-015 SEED SHALL load seed into the LFSR, substituting 8'h01 when seed==0.
REQ-016 LFSR SHALL be 8-bit Fibonacci, feedback lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3], shift left, advancing every cycle except the SEED load cycle.
REQ-017 SHUFFLE SHALL run FSM IDLE->MERGE->SWAP->IDLE, with busy=1 in MERGE and SWAP.
REQ-018 MERGE (1 cycle) SHALL append discard liberals then discard fascists at positions draw_n upward, set draw_n+=discard_n and discard_n=0, and set i=draw_n-1 (new value).
REQ-019 SWAP SHALL make one attempt per cycle with j=lfsr[4:0]: if j<=i, swap draw[i] and draw[j] and decrement i; otherwise retry next cycle.
REQ-020 SWAP SHALL exit to IDLE when i==0, or immediately when draw_n<=1.
REQ-021 A DISCARD or PLAY that leaves draw_n<3 SHALL enter MERGE on the next cycle automatically.
REQ-022 Population count of draw plus discard liberals plus lib_played SHALL always equal 6.

Reset
REQ-023 rst_n low SHALL asynchronously force: state IDLE, draw=17'h0003F, draw_n=17, discard_n=0, lib_played=0, fas_played=0, game_over=0, op_err=0, busy=0, op_ready=1, LFSR=8'h01.
REQ-024 Reset asserted mid-SHUFFLE SHALL abort the shuffle and apply REQ-023 values.

Structure
REQ-025 Opcode constants, DECK_SIZE=17, LIB_TOTAL=6, LIB_WIN=5 and FAS_WIN=6 SHALL reside in shared package snpu_pkg.
REQ-026 The LFSR SHALL be sub-module snpu_lfsr8, with ports clk, rst_n, load, seed, and q[7:0].

Verification
REQ-027 Bench SHALL cover: reset -> draw_n=17, hand=3'b111, discard_n=0, op_ready=1, busy=0.
REQ-028 Bench SHALL cover: after reset, PLAY idx=0 -> lib_played=1, draw_n=16, draw=17'h0001F.
REQ-029 Bench SHALL cover: DISCARD idx=3 -> op_err high exactly one cycle, all counts unchanged.
REQ-030 Bench SHALL cover: from reset, 15 DISCARD idx=2 -> busy rises the next cycle; on return to IDLE, draw_n=17, discard_n=0, popcount(draw)=6.
REQ-031 Bench SHALL cover: SEED 8'hA5 then SHUFFLE -> IDLE reached within 600 cycles, popcount preserved, and the identical result produced on repeat.
REQ-032 Bench SHALL cover: rst_n pulsed low while busy=1 -> outputs match REQ-023 in the same cycle.
